// File: rtl/pc_fetch_gen_if.sv
// Fetch request bus between the IF1 PC generator and the icache.
// Parameter:
//   FETCH_WIDTH - instruction slots per fetch group.
// Signals:
//   fetch_valid - request valid (generator -> icache)
//   fetch_ready - icache accepts the request (icache -> generator)
//   fetch_pc    - PC of the first valid slot
//   fetch_mask  - valid instruction slots in the group
//   fetch_adef  - fetch_pc is not word aligned
// Modports: master (generator side), slave (icache side).
interface pc_fetch_gen_if #(
    parameter int unsigned FETCH_WIDTH = 2
);
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [31:0]            fetch_pc;
    logic [FETCH_WIDTH-1:0] fetch_mask;
    logic                   fetch_adef;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_mask,
        output fetch_adef,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_mask,
        input  fetch_adef,
        output fetch_ready
    );
endinterface

// File: rtl/pc_fetch_gen.sv
// IF1 next-PC generator. Issues aligned multi-instruction fetch groups to the
// icache over a valid/ready handshake, follows backend flushes and predictor
// redirects, and stops fetching after an address-misaligned (ADEF) fetch until
// the backend flushes.
//
// Optional feature macro: PC_IDLE_EN (adds an IDLE state entered by a flush
// with idle_req and left by wake or a plain flush).
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   flush_valid, flush_pc - backend redirect, highest priority
//   bp_valid, bp_target   - predictor redirect for the group accepted this cycle
//   idle_req, wake        - idle control (only used with PC_IDLE_EN)
//   fetch                 - fetch request bus (master side)
module pc_fetch_gen #(
    parameter logic [31:0] PC_INITIAL  = 32'h1c00_0000,
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_valid,
    input  logic [31:0]           flush_pc,
    input  logic                  bp_valid,
    input  logic [31:0]           bp_target,
    input  logic                  idle_req,
    input  logic                  wake,
    pc_fetch_gen_if.master        fetch
);
    localparam int unsigned GROUP_BYTES = 4 * FETCH_WIDTH;
    localparam logic [31:0] GroupMask   = 32'(GROUP_BYTES - 1);
    localparam logic [31:0] SlotMask    = 32'(FETCH_WIDTH - 1);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFault = 2'd2;
    localparam logic [1:0] StIdle  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   accept;
    logic                   adef;
    logic [31:0]            slot;
    logic [FETCH_WIDTH-1:0] ones;
    logic [FETCH_WIDTH-1:0] mask;
    logic [31:0]            pc_seq;

`ifndef PC_IDLE_EN
    // Idle controls exist only for port compatibility in this build.
    logic unused_idle;
    assign unused_idle = idle_req ^ wake;
`endif

    assign adef   = pc_q[1:0] != 2'b00;
    // Slot index of fetch_pc inside its group; collapses to 0 for FETCH_WIDTH=1.
    assign slot   = (pc_q >> 2) & SlotMask;
    assign ones   = '1;
    assign accept = (state_q == StRun) && fetch.fetch_ready;
    // Sequential successor: next group boundary, wrapping modulo 2^32.
    assign pc_seq = (pc_q & ~GroupMask) + 32'(GROUP_BYTES);

    always_comb begin
        mask = '0;
        if (state_q == StRun) begin
            // A misaligned fetch only carries the faulting slot.
            if (adef) begin
                mask = {{(FETCH_WIDTH-1){1'b0}}, 1'b1} << slot;
            end else begin
                mask = ones << slot;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == StBoot) begin
            // Flush during boot is latched but does not delay entering RUN.
            state_d = StRun;
            if (flush_valid) begin
                pc_d = flush_pc;
            end
        end else if (flush_valid) begin
            pc_d    = flush_pc;
            state_d = StRun;
`ifdef PC_IDLE_EN
            if (idle_req) begin
                state_d = StIdle;
            end
`endif
        end else if (accept && adef) begin
            state_d = StFault;
        end else if (accept && bp_valid) begin
            pc_d = bp_target;
        end else if (accept) begin
            pc_d = pc_seq;
`ifdef PC_IDLE_EN
        end else if (state_q == StIdle && wake) begin
            state_d = StRun;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= PC_INITIAL;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign fetch.fetch_valid = state_q == StRun;
    assign fetch.fetch_pc    = pc_q;
    assign fetch.fetch_mask  = mask;
    assign fetch.fetch_adef  = adef;
endmodule

// File: tb/tb_pc_fetch_gen.sv
module tb_pc_fetch_gen;
    localparam int unsigned FW  = 2;
    localparam int unsigned GB  = 4 * FW;
    localparam logic [31:0] PCI = 32'h1c00_0000;

    localparam int MBoot  = 0;
    localparam int MRun   = 1;
    localparam int MFault = 2;
    localparam int MIdle  = 3;

    typedef struct {
        logic          valid;
        logic [31:0]   pc;
        logic [FW-1:0] mask;
        logic          adef;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        bp_valid = 1'b0;
    logic [31:0] bp_target = '0;
    logic        idle_req = 1'b0;
    logic        wake = 1'b0;

    pc_fetch_gen_if #(.FETCH_WIDTH(FW)) fif ();

    pc_fetch_gen #(
        .PC_INITIAL (PCI),
        .FETCH_WIDTH(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_valid(flush_valid),
        .flush_pc   (flush_pc),
        .bp_valid   (bp_valid),
        .bp_target  (bp_target),
        .idle_req   (idle_req),
        .wake       (wake),
        .fetch      (fif.master)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: architectural mode and PC as the spec describes them.
    int          m_mode = MBoot;
    logic [31:0] m_pc   = PCI;

    function automatic exp_t model_out();
        exp_t e;
        int   slot;
        e.pc   = m_pc;
        e.adef = (m_pc % 4) != 0;
        e.valid = (m_mode == MRun);
        slot = int'((m_pc / 4) % FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (!e.valid)     e.mask[i] = 1'b0;
            else if (e.adef)  e.mask[i] = (i == slot);
            else              e.mask[i] = (i >= slot);
        end
        return e;
    endfunction

    // One clock cycle of stimulus; the expectation for this cycle is queued
    // and the model advanced to what the next cycle should show.
    task automatic cyc(input bit r, input bit fl, input logic [31:0] fpc, input bit bv,
                       input logic [31:0] bt, input bit rdy, input bit idl, input bit wk);
        exp_t e;
        bit   idle_en;
`ifdef PC_IDLE_EN
        idle_en = 1'b1;
`else
        idle_en = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst = r; flush_valid = fl; flush_pc = fpc; bp_valid = bv; bp_target = bt;
        fif.fetch_ready = rdy; idle_req = idl; wake = wk;
        if (r) begin
            m_mode = MBoot;
            m_pc   = PCI;
        end
        e = model_out();
        exp_q.push_back(e);
        if (!r) begin
            if (m_mode == MBoot) begin
                m_mode = MRun;
                if (fl) m_pc = fpc;
            end else if (fl) begin
                m_pc   = fpc;
                m_mode = (idle_en && idl) ? MIdle : MRun;
            end else if (m_mode == MRun && rdy) begin
                if (e.adef)    m_mode = MFault;
                else if (bv)   m_pc = bt;
                else           m_pc = (m_pc / GB) * GB + GB;
            end else if (m_mode == MIdle && wk) begin
                m_mode = MRun;
            end
        end
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0, rdy, 0, 0);
    endtask

    task automatic flush(input logic [31:0] fpc, input bit rdy);
        cyc(0, 1, fpc, 0, '0, rdy, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            bit   bad;
            e   = exp_q.pop_front();
            bad = 1'b0;
            if (fif.fetch_valid !== e.valid) begin
                $display("FAIL valid @%0t: got %b want %b", $time, fif.fetch_valid, e.valid);
                bad = 1'b1;
            end
            if (fif.fetch_pc !== e.pc) begin
                $display("FAIL pc @%0t: got %h want %h", $time, fif.fetch_pc, e.pc);
                bad = 1'b1;
            end
            if (fif.fetch_mask !== e.mask) begin
                $display("FAIL mask @%0t: got %b want %b", $time, fif.fetch_mask, e.mask);
                bad = 1'b1;
            end
            if (fif.fetch_adef !== e.adef) begin
                $display("FAIL adef @%0t: got %b want %b", $time, fif.fetch_adef, e.adef);
                bad = 1'b1;
            end
            vectors++;
            if (bad) miscompares++;
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 5))
            0:       p = 32'hffff_ffe0 + ($urandom_range(0, 7) << 2);
            1:       p = 32'h1c00_0000 + $urandom_range(0, 255);
            default: p = 32'h1c00_0000 + ($urandom_range(0, 255) << 2);
        endcase
        return p;
    endfunction

    initial begin
        fif.fetch_ready = 1'b0;
        // Reset release and sequential groups.
        cyc(1, 0, '0, 0, '0, 1, 0, 0);
        cyc(1, 0, '0, 0, '0, 1, 0, 0);
        run(3, 1);
        // Stall at 0x1c000010 with a stray predictor pulse.
        cyc(0, 0, '0, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 1, 32'h1c00_0500, 0, 0, 0);
        cyc(0, 0, '0, 0, '0, 0, 0, 0);
        run(2, 1);
        // Flush into the second slot.
        flush(32'h1c00_0104, 1);
        run(2, 1);
        // Predictor redirect, then flush beating predictor.
        cyc(0, 0, '0, 1, 32'h1c00_0200, 1, 0, 0);
        cyc(0, 1, 32'h1c00_0300, 1, 32'h1c00_0200, 1, 0, 0);
        run(2, 1);
        // Misaligned fetch faults until a flush.
        flush(32'h1c00_0006, 1);
        run(4, 1);
        flush(32'h1c00_0800, 1);
        run(2, 1);
        // Address wrap.
        flush(32'hffff_fff8, 1);
        run(2, 1);
        // Flush while in boot, and reset mid-operation.
        cyc(1, 0, '0, 0, '0, 1, 0, 0);
        cyc(0, 1, 32'h1c00_0420, 0, '0, 1, 0, 0);
        run(2, 1);
`ifdef PC_IDLE_EN
        cyc(0, 1, 32'h1c00_0040, 0, '0, 1, 1, 0);
        run(5, 1);
        cyc(0, 0, '0, 0, '0, 1, 0, 1);
        run(2, 1);
`endif
        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), rand_pc(),
                ($urandom_range(0, 3) == 0), rand_pc(), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
            vectors++;
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
